// File: rtl/beepboop_pkg.sv
// Shared types and constants for the beepboop identifier-stream receiver.
// The default signature is left-aligned in an ID_MAX_CHARS-byte field.
package beepboop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } id_rx_state_t;

  localparam int ID_MAX_CHARS = 32;
  localparam int ID_SIG_LEN   = 23;

  // 23 characters (184 bits) followed by 9 zero bytes of padding.
  localparam logic [8*ID_MAX_CHARS-1:0] ID_SIG = {"Beep Boop Traffic Light", 72'h0};

  function automatic logic is_nul(input logic [7:0] b);
    return (b == 8'h00);
  endfunction

endpackage

// File: rtl/beepboop_id_rx_deser.sv
// Serial-to-parallel stage: MSB-first shift register with a 3-bit bit counter.
// The completed byte is presented combinationally alongside its 8th bit.
module id_rx_deser (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic       shift,
  input  logic       bit_in,
  output logic       byte_done,
  output logic [7:0] data
);

  // Only seven bits are stored; the eighth is the bit arriving this cycle.
  logic [6:0] shreg;
  logic [2:0] bit_cnt;

  // Shift register and bit counter.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      shreg   <= 7'h00;
      bit_cnt <= 3'd0;
    end else if (load) begin
      shreg   <= {6'h00, bit_in};
      bit_cnt <= 3'd1;
    end else if (shift) begin
      shreg   <= {shreg[5:0], bit_in};
      bit_cnt <= bit_cnt + 3'd1;
    end else begin
      shreg   <= shreg;
      bit_cnt <= bit_cnt;
    end
  end

  assign byte_done = shift && (bit_cnt == 3'd7);
  assign data      = {shreg, bit_in};

endmodule

// File: rtl/beepboop_id_rx.sv
// Identifier-message receiver: deserializes the one-bit ID stream, counts
// characters and flags terminator, truncation and overflow. Optional signature
// comparison is enabled with BEEPBOOP_ID_RX_SIG_CHECK_EN.
module beepboop_id_rx
  import beepboop_pkg::*;
#(
  parameter int                     MAX_CHARS = ID_MAX_CHARS,
  parameter int                     SIG_LEN   = ID_SIG_LEN,
  parameter logic [8*MAX_CHARS-1:0] SIG       = ID_SIG
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           bit_in,
  input  logic                           bit_valid,
  input  logic                           clear,
  output logic [7:0]                     byte_out,
  output logic                           byte_valid,
  output logic [$clog2(MAX_CHARS+1)-1:0] char_count,
  output logic                           msg_done,
  output logic                           frame_err,
  output logic                           overflow,
  output logic                           sig_match
);

  localparam int            CW    = $clog2(MAX_CHARS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_CHARS);

  // A signature whose first character is NUL can never be matched.
  if ((SIG_LEN > MAX_CHARS) || ((SIG_LEN > 0) && (SIG[8*MAX_CHARS-1 -: 8] == 8'h00))) begin : g_bad_sig
    $error("beepboop_id_rx: inconsistent SIG/SIG_LEN configuration");
  end

  id_rx_state_t  state, state_nxt;
  logic [7:0]    byte_out_nxt;
  logic          byte_valid_nxt;
  logic [CW-1:0] count_nxt;
  logic          msg_done_nxt, frame_err_nxt, overflow_nxt, sig_match_nxt;
  logic          load, shift, byte_done;
  logic [7:0]    rx_byte;

  id_rx_deser u_deser (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .load      (load),
    .shift     (shift),
    .bit_in    (bit_in),
    .byte_done (byte_done),
    .data      (rx_byte)
  );

`ifdef BEEPBOOP_ID_RX_SIG_CHECK_EN
  localparam int            IW        = $clog2(MAX_CHARS);
  localparam logic [CW-1:0] SIG_LEN_C = CW'(SIG_LEN);

  logic [7:0]    sig_chars [MAX_CHARS];
  logic [IW-1:0] char_idx;
  logic          mismatch, mismatch_nxt;

  for (genvar k = 0; k < MAX_CHARS; k++) begin : g_sig
    assign sig_chars[k] = SIG[8*(MAX_CHARS-1-k) +: 8];
  end

  // Only read while char_count < MAX_CHARS, so truncation is harmless.
  assign char_idx = char_count[IW-1:0];

  // Sticky signature-mismatch bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      mismatch <= 1'b0;
    end else begin
      mismatch <= mismatch_nxt;
    end
  end
`endif

  // Next-state, counter and flag logic; clear overrides everything.
  always_comb begin
    state_nxt      = state;
    byte_out_nxt   = byte_out;
    byte_valid_nxt = 1'b0;
    count_nxt      = char_count;
    msg_done_nxt   = msg_done;
    frame_err_nxt  = frame_err;
    overflow_nxt   = overflow;
    sig_match_nxt  = sig_match;
    load           = 1'b0;
    shift          = 1'b0;
`ifdef BEEPBOOP_ID_RX_SIG_CHECK_EN
    mismatch_nxt   = mismatch;
`endif
    if (clear) begin
      state_nxt     = IDLE;
      count_nxt     = '0;
      msg_done_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
      overflow_nxt  = 1'b0;
      sig_match_nxt = 1'b0;
`ifdef BEEPBOOP_ID_RX_SIG_CHECK_EN
      mismatch_nxt  = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bit_valid) begin
            load      = 1'b1;
            state_nxt = RECV;
          end else begin
            state_nxt = IDLE;
          end
        end
        RECV: begin
          if (!bit_valid) begin
            frame_err_nxt = 1'b1;
            state_nxt     = ERROR;
          end else begin
            shift = 1'b1;
            if (!byte_done) begin
              state_nxt = RECV;
            end else if (is_nul(rx_byte)) begin
              msg_done_nxt = 1'b1;
              state_nxt    = DONE;
`ifdef BEEPBOOP_ID_RX_SIG_CHECK_EN
              sig_match_nxt = !mismatch && (char_count == SIG_LEN_C);
`endif
            end else if (char_count == MAX_C) begin
              overflow_nxt = 1'b1;
              state_nxt    = ERROR;
            end else begin
              byte_out_nxt   = rx_byte;
              byte_valid_nxt = 1'b1;
              count_nxt      = char_count + {{(CW-1){1'b0}}, 1'b1};
`ifdef BEEPBOOP_ID_RX_SIG_CHECK_EN
              if (rx_byte != sig_chars[char_idx]) begin
                mismatch_nxt = 1'b1;
              end else begin
                mismatch_nxt = mismatch;
              end
`endif
            end
          end
        end
        DONE: begin
          if (bit_valid) begin
            frame_err_nxt = 1'b1;
            state_nxt     = ERROR;
          end else begin
            state_nxt = DONE;
          end
        end
        ERROR:   state_nxt = ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      char_count <= '0;
      msg_done   <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      sig_match  <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_out   <= byte_out_nxt;
      byte_valid <= byte_valid_nxt;
      char_count <= count_nxt;
      msg_done   <= msg_done_nxt;
      frame_err  <= frame_err_nxt;
      overflow   <= overflow_nxt;
      sig_match  <= sig_match_nxt;
    end
  end

endmodule

// File: tb/tb_beepboop_id_rx.sv
// Scoreboard bench for beepboop_id_rx: a default instance and a MAX_CHARS=4
// instance share the stimulus bus, gated by sel.
module tb_beepboop_id_rx;

`ifdef BEEPBOOP_ID_RX_SIG_CHECK_EN
  localparam logic SIG_EXP = 1'b1;
`else
  localparam logic SIG_EXP = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, bit_in, bit_valid, clear, sel;
  logic bv0, clr0, bv1, clr1;
  assign bv0  = bit_valid & ~sel;
  assign clr0 = clear & ~sel;
  assign bv1  = bit_valid & sel;
  assign clr1 = clear & sel;

  logic [7:0] bo0, bo1;
  logic       bval0, bval1, done0, done1, ferr0, ferr1, ovf0, ovf1, sm0, sm1;
  logic [5:0] cnt0;
  logic [2:0] cnt1;

  beepboop_id_rx dut0 (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bv0), .clear(clr0),
    .byte_out(bo0), .byte_valid(bval0), .char_count(cnt0), .msg_done(done0),
    .frame_err(ferr0), .overflow(ovf0), .sig_match(sm0)
  );

  beepboop_id_rx #(.MAX_CHARS(4), .SIG_LEN(4), .SIG(32'h41424344)) dut1 (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bv1), .clear(clr1),
    .byte_out(bo1), .byte_valid(bval1), .char_count(cnt1), .msg_done(done1),
    .frame_err(ferr1), .overflow(ovf1), .sig_match(sm1)
  );

  int checks = 0;
  int failures = 0;
  int pulses0 = 0;
  int pulses1 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] tx[$];
  logic [7:0] e0, e1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every byte_valid pulse consumes one expected byte.
  always @(negedge clock) begin
    if (bval0 === 1'b1) begin
      pulses0++;
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL byte0_unexpected actual=0x%0h required=none", bo0);
      end else begin
        e0 = q0.pop_front();
        check("byte0", {24'h0, bo0}, {24'h0, e0});
      end
    end
    if (bval1 === 1'b1) begin
      pulses1++;
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL byte1_unexpected actual=0x%0h required=none", bo1);
      end else begin
        e1 = q1.pop_front();
        check("byte1", {24'h0, bo1}, {24'h0, e1});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_msg(input string s);
    tx.delete();
    for (int i = 0; i < s.len(); i++) tx.push_back(s[i]);
    tx.push_back(8'h00);
  endtask

  function automatic logic get_bit(input int i);
    logic [7:0] b;
    b = tx[i/8];
    return b[7-(i%8)];
  endfunction

  task automatic stream(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      @(negedge clock);
      bit_valid = 1'b1;
      bit_in    = get_bit(i);
    end
  endtask

  task automatic do_clear();
    @(negedge clock);
    bit_valid = 1'b0;
    clear     = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic push_msg0(input int n);
    for (int i = 0; i < n; i++) q0.push_back(tx[i]);
  endtask

  initial begin
    int p;
    logic [7:0] b;
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_byte_out", {24'h0, bo0}, 32'h00);
    check("rst_byte_valid", {31'h0, bval0}, 32'h0);
    check("rst_char_count", {26'h0, cnt0}, 32'd0);
    check("rst_flags", {28'h0, done0, ferr0, ovf0, sm0}, 32'h0);
    check("rst_flags_max4", {28'h0, done1, ferr1, ovf1, sm1}, 32'h0);

    // Full identifier message, 192 contiguous bits.
    set_msg("Beep Boop Traffic Light");
    push_msg0(23);
    p = pulses0;
    stream(0, 191);
    @(negedge clock);
    check("full_done_before_last_bit", {31'h0, done0}, 32'h0);
    check("full_count_before_last_bit", {26'h0, cnt0}, 32'd23);
    bit_valid = 1'b1; bit_in = get_bit(191);
    @(negedge clock);
    bit_valid = 1'b0;
    check("full_msg_done", {31'h0, done0}, 32'h1);
    check("full_char_count", {26'h0, cnt0}, 32'd23);
    check("full_frame_err", {31'h0, ferr0}, 32'h0);
    check("full_last_byte", {24'h0, bo0}, 32'h74);
    check("full_sig_match", {31'h0, sm0}, {31'h0, SIG_EXP});
    check("full_pulses", pulses0 - p, 32'd23);

    // One extra valid bit after the terminator.
    @(negedge clock);
    bit_valid = 1'b1; bit_in = 1'b0;
    @(negedge clock);
    bit_valid = 1'b0;
    check("extra_bit_frame_err", {31'h0, ferr0}, 32'h1);
    check("extra_bit_msg_done", {31'h0, done0}, 32'h1);

    // Short message "Hi".
    do_clear();
    check("clear_flags", {28'h0, done0, ferr0, ovf0, sm0}, 32'h0);
    check("clear_byte_out_holds", {24'h0, bo0}, 32'h74);
    set_msg("Hi");
    q0.push_back(8'h48); q0.push_back(8'h69);
    stream(0, 24);
    @(negedge clock);
    bit_valid = 1'b0;
    check("hi_char_count", {26'h0, cnt0}, 32'd2);
    check("hi_msg_done", {31'h0, done0}, 32'h1);
    check("hi_sig_match", {31'h0, sm0}, 32'h0);

    // Truncated after 13 bits.
    do_clear();
    q0.push_back(8'h48);
    stream(0, 13);
    @(negedge clock);
    bit_valid = 1'b0;
    check("trunc_no_err_yet", {31'h0, ferr0}, 32'h0);
    @(negedge clock);
    check("trunc_frame_err", {31'h0, ferr0}, 32'h1);
    check("trunc_msg_done", {31'h0, done0}, 32'h0);
    check("trunc_char_count", {26'h0, cnt0}, 32'd1);
    do_clear();
    check("trunc_clear_flags", {28'h0, done0, ferr0, ovf0, sm0}, 32'h0);
    check("trunc_clear_count", {26'h0, cnt0}, 32'd0);
    check("trunc_clear_byte_out", {24'h0, bo0}, 32'h48);

    // Reset after 100 bits, then the remaining 92 bits form a misaligned message.
    set_msg("Beep Boop Traffic Light");
    push_msg0(12);
    stream(0, 100);
    @(negedge clock);
    bit_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_byte_out", {24'h0, bo0}, 32'h00);
    check("midrst_char_count", {26'h0, cnt0}, 32'd0);
    check("midrst_flags", {28'h0, done0, ferr0, ovf0, sm0}, 32'h0);
    for (int j = 0; j < 11; j++) begin
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], get_bit(100 + 8*j + k)};
      if (b == 8'h00) break;
      q0.push_back(b);
    end
    stream(100, 92);
    @(negedge clock);
    bit_valid = 1'b0;
    @(negedge clock);
    check("midrst_frame_err", {31'h0, ferr0}, 32'h1);
    check("midrst_msg_done", {31'h0, done0}, 32'h0);
    check("midrst_tail_count", {26'h0, cnt0}, 32'd11);
    do_clear();
    push_msg0(23);
    stream(0, 192);
    @(negedge clock);
    bit_valid = 1'b0;
    check("fresh_msg_done", {31'h0, done0}, 32'h1);
    check("fresh_char_count", {26'h0, cnt0}, 32'd23);
    check("fresh_frame_err", {31'h0, ferr0}, 32'h0);
    check("fresh_sig_match", {31'h0, sm0}, {31'h0, SIG_EXP});

    // Overflow on the MAX_CHARS=4 instance.
    sel = 1'b1;
    set_msg("ABCDE");
    q1.push_back(8'h41); q1.push_back(8'h42); q1.push_back(8'h43); q1.push_back(8'h44);
    p = pulses1;
    stream(0, 39);
    @(negedge clock);
    check("ovf_not_yet", {31'h0, ovf1}, 32'h0);
    check("ovf_count_at_max", {29'h0, cnt1}, 32'd4);
    bit_valid = 1'b1; bit_in = get_bit(39);
    @(negedge clock);
    check("ovf_set", {31'h0, ovf1}, 32'h1);
    bit_valid = 1'b1; bit_in = get_bit(40);
    stream(41, 7);
    @(negedge clock);
    bit_valid = 1'b0;
    @(negedge clock);
    check("ovf_held", {31'h0, ovf1}, 32'h1);
    check("ovf_no_msg_done", {31'h0, done1}, 32'h0);
    check("ovf_no_frame_err", {31'h0, ferr1}, 32'h0);
    check("ovf_pulses", pulses1 - p, 32'd4);
    do_clear();
    check("ovf_clear", {31'h0, ovf1}, 32'h0);
    sel = 1'b0;

    repeat (2) @(negedge clock);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beepboop_id_rx.md
# beepboop_id_rx

Serial identifier-message receiver: the listening end of the one-bit ID stream emitted by the traffic-light chip (`bit_in` = character bit, `bit_valid` = stream valid). It deserializes the MSB-first bit stream into bytes, reports each character, counts characters and detects the NUL terminator. It flags truncation and overflow, and can optionally check the message against a compiled-in signature. It sits on the bring-up/test board side, fed directly from the chip's output pins after synchronization.

## Interface
- `MAX_CHARS`, 32: maximum non-NUL characters accepted per message.
- `SIG_LEN`, 23: expected signature length in characters, excluding NUL. Used only with signature check.
- `SIG`, "Beep Boop Traffic Light": expected signature, character 0 in the MSBs, width 8*`MAX_CHARS`, left-aligned.
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `bit_in` input 1: serial data bit, sampled when `bit_valid`=1.
- `bit_valid` input 1: stream valid, high for consecutive cycles covering the whole message.
- `clear` input 1: abandon or finish the current message and return to IDLE.
- `byte_out` output 8: last completed non-NUL character.
- `byte_valid` output 1: one-cycle pulse when `byte_out` updates.
- `char_count` output $clog2(`MAX_CHARS`+1): non-NUL characters received.
- `msg_done` output 1: sticky; a NUL terminator was received.
- `frame_err` output 1: sticky; truncated or malformed stream.
- `overflow` output 1: sticky; more than `MAX_CHARS` characters received.
- `sig_match` output 1: sticky; message equals `SIG`. Driven 0 without the macro.

## Operation
- States: IDLE, RECV, DONE, ERROR.
- IDLE: on `bit_valid`=1, shift `bit_in` into bit 0 of the shift register, set `bit_cnt`=1, go to RECV.
- RECV, `bit_valid`=1: shift left, insert `bit_in` at LSB, increment `bit_cnt` mod 8.
- RECV, 8th bit sampled, assembled byte != 0x00:
  - If `char_count`==`MAX_CHARS`: set `overflow`, go to ERROR.
  - Otherwise: load `byte_out`, pulse `byte_valid`, increment `char_count`.
- RECV, 8th bit sampled, assembled byte == 0x00: set `msg_done`, go to DONE. No `byte_valid` for NUL; `byte_out` holds the last character.
- RECV, `bit_valid`=0 at any bit position, including a byte boundary before NUL: set `frame_err`, go to ERROR.
- DONE: `bit_valid`=1 sets `frame_err` and goes to ERROR. `msg_done` stays set.
- ERROR: holds all flags until `clear`.
- `clear` in any state:
  - Next state IDLE; `char_count`, `bit_cnt` and all sticky flags cleared.
  - `byte_out` holds its value.
  - `clear` has priority over a simultaneous `bit_valid`; that bit is discarded.
- Reset values: `byte_out`=0x00, `byte_valid`=0, `char_count`=0, `msg_done`=0, `frame_err`=0, `overflow`=0, `sig_match`=0; state IDLE, `bit_cnt`=0.
- Reset mid-message is identical to reset from idle. Any remaining stream bits then start a new message, which ends in `frame_err` unless aligned to a byte boundary.

## Timing
- All outputs are registered.
- `byte_valid`/`byte_out` update the cycle after the 8th bit of a byte is sampled.
- `msg_done` rises the cycle after the last NUL bit is sampled.
- `frame_err` rises the cycle after `bit_valid` is first sampled low in RECV.
- The bit stream runs at one bit per clock with no gaps. A full "Beep Boop Traffic Light"+NUL message is 192 consecutive valid cycles, giving `msg_done` at cycle 193 with `char_count`=23.

## Configuration
- `BEEPBOOP_ID_RX_SIG_CHECK_EN` defined:
  - Each completed non-NUL byte k is compared with `SIG` character k; any mismatch sets an internal sticky mismatch bit.
  - On NUL, `sig_match` sets iff there was no mismatch and `char_count`==`SIG_LEN`.
  - `clear` and reset clear both the mismatch bit and `sig_match`.
- `BEEPBOOP_ID_RX_SIG_CHECK_EN` undefined: no comparator logic; `sig_match` is tied to 0.

## Structure
- Shared package `beepboop_pkg`: state enum `id_rx_state_t` {IDLE, RECV, DONE, ERROR}, `ID_MAX_CHARS`=32, default signature constant `ID_SIG` and `ID_SIG_LEN`=23.
- One sub-module, `id_rx_deser`: shift register plus `bit_cnt`, producing `byte_done` and the assembled byte. The top level holds the FSM, counters, flags and the signature compare.

## Test plan
- "Beep Boop Traffic Light"+NUL, 192 contiguous bits:
  - 23 `byte_valid` pulses; first `byte_out`=0x42, last 0x74.
  - `char_count`=23, `msg_done`=1 at cycle 193, `frame_err`=0.
  - `sig_match`=1 with the macro, 0 without.
- "Hi"+NUL (0x48, 0x69, 0x00; 24 bits): `char_count`=2, `msg_done`=1; `sig_match`=0 with the macro (length and content mismatch).
- `bit_valid` dropped after 13 bits of "Hi": one `byte_valid` (0x48), then `frame_err`=1, `msg_done`=0; `clear` returns all flags to 0 and `char_count` to 0.
- `MAX_CHARS`=4, "ABCDE"+NUL: four `byte_valid` pulses, then `overflow`=1 at the 5th byte, state ERROR, no `msg_done`.
- After `msg_done`, one further valid bit: `frame_err`=1, `msg_done` stays 1.
- `reset` asserted at bit 100 of the full message, remaining 92 bits streamed: `frame_err`=1 when the stream ends; then `clear` plus a fresh 192-bit message gives `msg_done`=1, `char_count`=23.
